// File: rtl/sha256_core.sv
// Iterative SHA-256 compression engine: one round per clock, 64 rounds per block.
// Chaining value H persists across blocks until a soft or hard reset.
module sha256_core (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_hash_i,
  input  logic         reset_hash_i,
  input  logic [511:0] block_i,
  output logic         idle_o,
  output logic         hold_o,
  output logic [255:0] digest_o,
  output logic         digest_valid_o
);

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;
  localparam int ROUNDS   = 64;

  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  // K[t] sits at bits [32*t +: 32]; the list is written from K[63] down to K[0].
  localparam logic [2047:0] K_TABLE = {
    32'hc67178f2, 32'hbef9a3f7, 32'ha4506ceb, 32'h90befffa, 32'h8cc70208, 32'h84c87814, 32'h78a5636f, 32'h748f82ee,
    32'h682e6ff3, 32'h5b9cca4f, 32'h4ed8aa4a, 32'h391c0cb3, 32'h34b0bcb5, 32'h2748774c, 32'h1e376c08, 32'h19a4c116,
    32'h106aa070, 32'hf40e3585, 32'hd6990624, 32'hd192e819, 32'hc76c51a3, 32'hc24b8b70, 32'ha81a664b, 32'ha2bfe8a1,
    32'h92722c85, 32'h81c2c92e, 32'h766a0abb, 32'h650a7354, 32'h53380d13, 32'h4d2c6dfc, 32'h2e1b2138, 32'h27b70a85,
    32'h14292967, 32'h06ca6351, 32'hd5a79147, 32'hc6e00bf3, 32'hbf597fc7, 32'hb00327c8, 32'ha831c66d, 32'h983e5152,
    32'h76f988da, 32'h5cb0a9dc, 32'h4a7484aa, 32'h2de92c6f, 32'h240ca1cc, 32'h0fc19dc6, 32'hefbe4786, 32'he49b69c1,
    32'hc19bf174, 32'h9bdc06a7, 32'h80deb1fe, 32'h72be5d74, 32'h550c7dc3, 32'h243185be, 32'h12835b01, 32'hd807aa98,
    32'hab1c5ed5, 32'h923f82a4, 32'h59f111f1, 32'h3956c25b, 32'he9b5dba5, 32'hb5c0fbcf, 32'h71374491, 32'h428a2f98
  };

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] hv    [8];
  logic [31:0] work  [8];
  logic [31:0] work_nxt [8];
  logic [31:0] w     [16];
  logic [31:0] w_new;
  logic [31:0] t1, t2;
  logic        last_round;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign last_round = (state == COMPUTE) && (cnt == 6'(ROUNDS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (reset_hash_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (enable_hash_i) state_nxt = COMPUTE;
        COMPUTE:    if (last_round)    state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    idle_o         = (state == IDLE);
    hold_o         = (state == DONE);
    digest_valid_o = (state == DONE);
  end

  // w[0] is W[t] for the current round; w[15] receives W[t+16] as the window shifts.
  always_comb begin
    t1 = work[7] + big_sigma1(work[4]) + ((work[4] & work[5]) ^ (~work[4] & work[6]))
         + K_TABLE[{cnt, 5'b0} +: 32] + w[0];
    t2 = big_sigma0(work[0]) + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));
    work_nxt[0] = t1 + t2;
    work_nxt[1] = work[0];
    work_nxt[2] = work[1];
    work_nxt[3] = work[2];
    work_nxt[4] = work[3] + t1;
    work_nxt[5] = work[4];
    work_nxt[6] = work[5];
    work_nxt[7] = work[6];
    w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      for (int i = 0; i < DIGEST_W / 32; i++) begin
        hv[i]   <= IV[32*i +: 32];
        work[i] <= '0;
      end
      for (int i = 0; i < BLOCK_W / 32; i++) w[i] <= '0;
    end else if (reset_hash_i) begin
      cnt <= '0;
      for (int i = 0; i < DIGEST_W / 32; i++) hv[i] <= IV[32*i +: 32];
    end else if (state == COMPUTE) begin
      cnt <= cnt + 6'd1;
      for (int i = 0; i < DIGEST_W / 32; i++) begin
        work[i] <= work_nxt[i];
        if (last_round) hv[i] <= hv[i] + work_nxt[i];
      end
      for (int i = 0; i < BLOCK_W / 32 - 1; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end else if (enable_hash_i) begin
      cnt <= '0;
      for (int i = 0; i < DIGEST_W / 32; i++) work[i] <= hv[i];
      for (int i = 0; i < BLOCK_W / 32; i++) w[i] <= block_i[32*i +: 32];
    end
  end

  always_comb begin
    digest_o = '0;
    for (int i = 0; i < DIGEST_W / 32; i++) digest_o[32*i +: 32] = hv[i];
  end

endmodule
